// File: rtl/lab46_shift_seq_if.sv
// rtl/lab46_shift_seq_if.sv - request/result handshake bundle for the sequential shifter
interface lab46_shift_seq_if #(
    parameter int W     = 6,
    parameter int AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic             dir;
    logic [1:0]       cmd;
    logic [AMT_W-1:0] amt;
    logic [W-1:0]     din;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     dout;

    modport master (
        output in_valid, dir, cmd, amt, din, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, dir, cmd, amt, din, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/lab46_shift_seq.sv
// rtl/lab46_shift_seq.sv - multi-position shifter, one single-position step per clock
module lab46_shift_seq #(
    parameter int W     = 6,
    parameter int AMT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lab46_shift_seq_if.slave      bus,
    output logic                  busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [AMT_W-1:0] W_CNT = AMT_W'(W);

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [W-1:0]     dout_q, dout_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic [1:0]       cmd_q, cmd_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [AMT_W-1:0] eff_cnt;
    logic             accept;

    function automatic logic [W-1:0] step(input logic [W-1:0] d, input logic dr,
                                          input logic [1:0] c);
        logic [W-1:0] r;
        r = d;
        if (c != 2'b11) begin
            if (!dr) begin
                r = (c == 2'b10) ? {d[W-2:0], d[W-1]} : {d[W-2:0], 1'b0};
            end else begin
                case (c)
                    2'b00:   r = {1'b0, d[W-1:1]};
                    2'b01:   r = {d[W-1], d[W-1:1]};
                    default: r = {d[0], d[W-1:1]};
                endcase
            end
        end
        return r;
    endfunction

    // cmd 11 is a pass-through, so it skips SHIFT entirely
    always_comb begin
        eff_cnt = bus.amt;
        if (bus.cmd == 2'b11) begin
            eff_cnt = '0;
        end else if (bus.amt > W_CNT) begin
            eff_cnt = W_CNT;
        end
    end

    assign accept = bus.in_valid & ready_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dout_d  = dout_q;
        count_d = count_q;
        dir_d   = dir_q;
        cmd_d   = cmd_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = bus.din;
                    dir_d   = bus.dir;
                    cmd_d   = bus.cmd;
                    count_d = eff_cnt;
                    state_d = (eff_cnt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                data_d  = step(data_q, dir_q, cmd_q);
                count_d = count_q - 1'b1;
                if (count_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // first DONE cycle publishes the result; dout never sees SHIFT values
                if (!valid_q) begin
                    valid_d = 1'b1;
                    dout_d  = data_q;
                end else if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            dout_q  <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            cmd_q   <= 2'b00;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            cmd_q   <= cmd_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.dout      = dout_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_lab46_shift_seq.sv
// tb/tb_lab46_shift_seq.sv - scoreboard bench for lab46_shift_seq
module tb_lab46_shift_seq;
    logic clk;
    logic rst_n;
    logic busy;
    int   cyc;
    int   n_vec;
    int   n_err;

    lab46_shift_seq_if #(.W(6), .AMT_W(3)) bus ();

    lab46_shift_seq #(.W(6), .AMT_W(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct {
        logic [5:0] d;
        int         lat;
        int         t;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic       pv;
    logic [5:0] pd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops on each rising out_valid, checks value and latency
    initial begin
        pv = 1'b0;
        pd = '0;
    end
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && !pv) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_result: got dout %b expected no result", bus.dout);
                end else begin
                    e = sb.pop_front();
                    chk("dout", 32'(bus.dout), 32'(e.d));
                    chk("latency", 32'(cyc - e.t), 32'(e.lat));
                end
            end else if (bus.dout !== pd) begin
                n_vec++;
                n_err++;
                $display("FAIL dout_glitch: got %b expected %b", bus.dout, pd);
            end
        end
        pv = bus.out_valid;
        pd = bus.dout;
    end

    task automatic send(input logic [5:0] d, input logic dr, input logic [1:0] c,
                        input logic [2:0] a, input logic [5:0] ex, input int lat,
                        input bit push, output int t_acc);
        int n;
        exp_t x;
        n = 0;
        t_acc = -1;
        bus.in_valid = 1'b1;
        bus.din      = d;
        bus.dir      = dr;
        bus.cmd      = c;
        bus.amt      = a;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            t_acc = cyc;
            bus.in_valid = 1'b0;
            if (push) begin
                x.d   = ex;
                x.lat = lat;
                x.t   = t_acc;
                sb.push_back(x);
            end
        end
    endtask

    task automatic wait_done();
        int  n;
        bit  ok;
        ok = 1'b0;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic run(input logic [5:0] d, input logic dr, input logic [1:0] c,
                       input logic [2:0] a, input logic [5:0] ex, input int lat);
        int t;
        send(d, dr, c, a, ex, lat, 1'b1, t);
        wait_done();
    endtask

    initial begin
        int t;
        int hs;
        bit seen;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dir       = 1'b0;
        bus.cmd       = 2'b00;
        bus.amt       = '0;
        bus.din       = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run(6'b100101, 1'b0, 2'b10, 3'd2, 6'b010110, 3);
        run(6'b100101, 1'b1, 2'b01, 3'd3, 6'b111100, 4);
        run(6'b100101, 1'b1, 2'b00, 3'd1, 6'b010010, 2);
        run(6'b100101, 1'b1, 2'b10, 3'd1, 6'b110010, 2);
        run(6'b100101, 1'b0, 2'b00, 3'd7, 6'b000000, 7);
        run(6'b100101, 1'b0, 2'b11, 3'd5, 6'b100101, 1);
        run(6'b100101, 1'b0, 2'b01, 3'd1, 6'b001010, 2);
        run(6'b100101, 1'b1, 2'b10, 3'd6, 6'b100101, 7);
        run(6'b100101, 1'b1, 2'b01, 3'd6, 6'b111111, 7);
        run(6'b010110, 1'b1, 2'b01, 3'd7, 6'b000000, 7);
        run(6'b010110, 1'b0, 2'b00, 3'd0, 6'b010110, 1);

        // backpressure in DONE
        bus.out_ready = 1'b0;
        send(6'b110001, 1'b0, 2'b10, 3'd1, 6'b100011, 2, 1'b1, t);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_valid_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.din      = 6'b111111;
            bus.cmd      = 2'b11;
            bus.amt      = 3'd0;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_dout", 32'(bus.dout), 32'b100011);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        hs = cyc;
        chk("hs_out_valid", 32'(bus.out_valid), 32'd0);
        chk("hs_in_ready", 32'(bus.in_ready), 32'd1);
        send(6'b001101, 1'b1, 2'b00, 3'd2, 6'b000011, 3, 1'b1, t);
        chk("restart_edge", 32'(t - hs), 32'd1);
        wait_done();

        // reset mid-SHIFT aborts the operation
        send(6'b100101, 1'b0, 2'b10, 3'd6, 6'b000000, 0, 1'b0, t);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_dout", 32'(bus.dout), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("mid_rst_release_ready", 32'(bus.in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        run(6'b101100, 1'b0, 2'b01, 3'd2, 6'b110000, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lab46_shift_seq.md
Name: lab46_shift_seq

Overview:
- Sequential, multi-position counterpart to the lab45 single-step combinational shifter.
- Accepts a W-bit word plus a direction, a shift type and a shift amount over a valid/ready handshake.
- Applies one single-position shift per clock using the same cmd/dir semantics as lab45.
- Returns the result over a second valid/ready handshake; sits between a source register stage and a consumer in the lab4 datapath.

Parameters:
- W, 6, data width in bits.
- AMT_W, 3, width of amt port; must satisfy 2^AMT_W > W.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- dir  input  1  0 = left, 1 = right
- cmd  input  2  shift type, see Behaviour
- amt  input  AMT_W  number of positions to shift
- din  input  W  operand
- out_valid  output  1  result present on dout
- out_ready  input  1  consumer accepts result
- dout  output  W  result
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low, on ports clk and rst_n.
- Reset (rst_n low, effective immediately, no clock needed):
  - state = IDLE; data reg, count, dir/cmd regs = 0.
  - dout = 0, out_valid = 0, busy = 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 from the first clk edge after release.
- States:
  - IDLE: in_ready = 1.
  - SHIFT: in_ready = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Accept: when in_valid & in_ready at an edge, register din, dir, cmd and the effective count:
  - cmd = 11 → count 0.
  - amt > W → count W (clamp).
  - otherwise count = amt.
- Transition out of IDLE on accept:
  - count = 0 → DONE.
  - otherwise → SHIFT.
- SHIFT: each edge applies one single-position step to the data reg and decrements count. Leave for DONE on the edge where count goes 1 → 0.
- Single-step ops:
  - dir 0, cmd 00: {d[W-2:0],0}
  - dir 0, cmd 01: {d[W-2:0],0} (identical to cmd 00)
  - dir 0, cmd 10: rotate left, {d[W-2:0],d[W-1]}
  - dir 1, cmd 00: logical right, {0,d[W-1:1]}
  - dir 1, cmd 01: arithmetic right, {d[W-1],d[W-1:1]}
  - dir 1, cmd 10: rotate right, {d[0],d[W-1:1]}
  - cmd 11: no change, any dir
- Latency: with request accepted at edge t, out_valid rises after edge t+count+1; count 0 gives out_valid after t+1.
- DONE:
  - dout = data reg, held stable.
  - out_valid = 1 until an edge with out_ready = 1, then → IDLE with out_valid = 0.
  - No same-edge restart: the next accept occurs no earlier than the following edge.
- dout is registered. It keeps the last result after handshake and changes only when DONE is re-entered or on reset; it shows no intermediate SHIFT values externally.
- in_valid, din, dir, cmd and amt are ignored outside IDLE; no requirement to hold them after accept.
- Clamp consequences:
  - Logical/left shifts by ≥W give all zeros.
  - Arithmetic right by W gives all copies of the sign bit.
  - Rotate by W returns the original word.
- Reset mid-SHIFT or mid-DONE aborts the operation; no result is emitted after release.

Test Plan:
- Reset: rst_n low mid-SHIFT → out_valid = 0, dout = 000000, busy = 0 with no clock edge. After release and one edge → in_ready = 1.
- Rotate left: din = 100101, dir 0, cmd 10, amt 2, accepted at t.
  - After edge t+3: out_valid = 1, dout = 010110.
  - Intermediate value 001011 never appears on dout.
- Arithmetic right: din = 100101, dir 1, cmd 01, amt 3 → dout = 111100 after t+4.
- Other right shifts, amt 1, on din = 100101:
  - cmd 00 → dout = 010010.
  - cmd 10 → dout = 110010.
- Clamp and pass-through:
  - din = 100101, dir 0, cmd 00, amt 7 → clamped to 6, dout = 000000 after t+7.
  - cmd 11, amt 5 → dout = 100101 after t+1.
- Backpressure: out_ready held low 4 cycles in DONE.
  - dout and out_valid are stable throughout.
  - in_valid pulses during that time are not accepted (in_ready = 0).
  - out_ready high → IDLE next edge; the following request is accepted one edge later.
